ib_pack_wr_ctrl: RTL and testbench

Parametrised input-buffer write controller. It takes one serial binary activation bit per channel per valid beat, packs WORD_W bits into a word per channel, and generates per-channel RAM write data, address and write-enable for one frame of DEPTH words. Channel k runs k cycles behind channel 0 (optional), matching the skewed upstream layer output. Unlike the previous fixed 16x32x14 controller, it adds frame re-arm via start, mid-frame abort, an overflow flag and a single-cycle done pulse.

---
 rtl/ib_pack_wr_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ib_pack_wr_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ib_pack_wr_ctrl.sv
// Input-buffer write controller: packs serial activation bits into WORD_W-bit
// words per channel and emits per-channel RAM write data/address/enable for
// one frame of DEPTH words. Channel k optionally lags channel 0 by k cycles.
module ib_pack_wr_ctrl #(
  parameter int NUM_CH  = 16,
  parameter int WORD_W  = 32,
  parameter int DEPTH   = 14,
  parameter int AW      = 4,
  parameter int STAGGER = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     bin_val,
  input  logic [NUM_CH-1:0]        bin,
  output logic [NUM_CH*WORD_W-1:0] dout,
  output logic [NUM_CH*AW-1:0]     addr,
  output logic [NUM_CH-1:0]        wea,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int              BCW       = $clog2(WORD_W);
  localparam int              LAST_CH   = NUM_CH - 1;
  localparam logic [BCW-1:0]  BIT_LAST  = BCW'(WORD_W - 1);
  localparam logic [AW-1:0]   WORD_LAST = AW'(DEPTH - 1);
  localparam bit              SKEW      = (STAGGER != 0) && (NUM_CH > 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;

  logic [BCW-1:0]    bit_cnt;
  logic [AW-1:0]     word_cnt;
  logic              ch0_full;
  logic              wea0_q;
  logic [AW-1:0]     addr0_q;

  logic              accept;
  logic              overflow_beat;
  logic              last_bit;
  logic              ch0_last_write;
  logic              last_ch_last_write;

  logic [NUM_CH-1:0]    ch_val;
  logic [NUM_CH-1:0]    ch_wea;
  logic [NUM_CH*AW-1:0] ch_addr;

  // Channel 0 takes a beat only while running and before its frame is full;
  // a start in the same cycle always wins over the beat.
  assign accept        = bin_val && !start && (state == RUN) && !ch0_full;
  assign overflow_beat = bin_val && !start && ((state == RUN) || (state == DRAIN)) && ch0_full;
  assign last_bit      = (bit_cnt == BIT_LAST);

  assign ch0_last_write     = wea0_q && (addr0_q == WORD_LAST);
  assign last_ch_last_write = ch_wea[LAST_CH] && (ch_addr[LAST_CH*AW +: AW] == WORD_LAST);

  assign wea  = ch_wea;
  assign addr = ch_addr;

  // Frame sequencing next state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (start) state_nxt = RUN;
               else if (ch0_last_write) state_nxt = SKEW ? DRAIN : DONE;
      DRAIN:   if (start) state_nxt = RUN;
               else if (last_ch_last_write) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame state with registered busy/done derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done  <= (state_nxt == DONE);
    end
  end

  // Channel 0 bit/word counters, write strobe, address and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
      ch0_full <= 1'b0;
      wea0_q   <= 1'b0;
      addr0_q  <= '0;
      overflow <= 1'b0;
    end else if (start) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
      ch0_full <= 1'b0;
      wea0_q   <= 1'b0;
      addr0_q  <= '0;
      overflow <= 1'b0;
    end else begin
      wea0_q <= accept && last_bit;
      if (overflow_beat) overflow <= 1'b1;
      if (accept) begin
        if (last_bit) begin
          bit_cnt <= '0;
          addr0_q <= word_cnt;
          // word_cnt parks on the last address; ch0_full masks further beats.
          if (word_cnt == WORD_LAST) ch0_full <= 1'b1;
          else                       word_cnt <= word_cnt + AW'(1);
        end else begin
          bit_cnt <= bit_cnt + BCW'(1);
        end
      end
    end
  end

  generate
    if (SKEW) begin : g_skew
      logic [NUM_CH-2:0]        val_d;
      logic [(NUM_CH-1)*AW-1:0] addr_d;
      logic [NUM_CH-2:0]        wea_d;

      // Delay chains: tap k-1 holds channel 0's control delayed k cycles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          val_d  <= '0;
          wea_d  <= '0;
          addr_d <= '0;
        end else if (start) begin
          val_d  <= '0;
          wea_d  <= '0;
          addr_d <= '0;
        end else begin
          val_d  <= (NUM_CH-1)'({val_d, accept});
          wea_d  <= (NUM_CH-1)'({wea_d, wea0_q});
          addr_d <= ((NUM_CH-1)*AW)'({addr_d, addr0_q});
        end
      end

      assign ch_val  = {val_d, accept};
      assign ch_wea  = {wea_d, wea0_q};
      assign ch_addr = {addr_d, addr0_q};
    end else begin : g_flat
      assign ch_val  = {NUM_CH{accept}};
      assign ch_wea  = {NUM_CH{wea0_q}};
      assign ch_addr = {NUM_CH{addr0_q}};
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [WORD_W-1:0] word_q;

      // MSB-first shift of this channel's serial bit on its own valid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         word_q <= '0;
        else if (start)     word_q <= '0;
        else if (ch_val[k]) word_q <= {word_q[WORD_W-2:0], bin[k]};
      end

      assign dout[k*WORD_W +: WORD_W] = word_q;
    end
  endgenerate

endmodule

// File: tb/tb_ib_pack_wr_ctrl.sv
// Scoreboard bench for ib_pack_wr_ctrl: default staggered instance plus a
// small aligned instance (NUM_CH=4, WORD_W=8, DEPTH=3, STAGGER=0).
module tb_ib_pack_wr_ctrl;
  localparam int NUM_CH = 16, WORD_W = 32, DEPTH = 14, AW = 4;
  localparam int HMASK  = 8191;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                     start = 1'b0, bin_val = 1'b0;
  logic [NUM_CH-1:0]        bin = '0;
  logic [NUM_CH*WORD_W-1:0] dout;
  logic [NUM_CH*AW-1:0]     addr;
  logic [NUM_CH-1:0]        wea;
  logic                     busy, done, overflow;

  logic       start2 = 1'b0, bin_val2 = 1'b0;
  logic [3:0] bin2 = '0;
  logic [31:0] dout2;
  logic [7:0]  addr2;
  logic [3:0]  wea2;
  logic        busy2, done2, overflow2;

  ib_pack_wr_ctrl #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .DEPTH(DEPTH), .AW(AW), .STAGGER(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_val(bin_val), .bin(bin),
    .dout(dout), .addr(addr), .wea(wea), .busy(busy), .done(done), .overflow(overflow));

  ib_pack_wr_ctrl #(.NUM_CH(4), .WORD_W(8), .DEPTH(3), .AW(2), .STAGGER(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin_val(bin_val2), .bin(bin2),
    .dout(dout2), .addr(addr2), .wea(wea2), .busy(busy2), .done(done2), .overflow(overflow2));

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
  endtask

  typedef struct packed { int cyc; logic [AW-1:0] a; logic [WORD_W-1:0] d; } wr_t;
  typedef struct packed { int cyc; logic [1:0] a; logic [31:0] d; } w2_t;

  wr_t exp_q [NUM_CH][$];
  int  done_q[$];
  w2_t q2[$];
  int  done2_q[$];

  logic [NUM_CH-1:0] hist [0:HMASK];
  logic [WORD_W-1:0] mword [NUM_CH];
  int  mbits = 0, mwords = 0;
  bit  mfull = 1'b0, m_ovf = 1'b0;
  int  run_from = -1, run_until = 0;

  function automatic bit in_frame(input int c);
    return (run_from >= 0) && (c >= run_from) && (c < run_until);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus for the main instance plus the reference model update.
  task automatic drive(input bit s, input bit v, input logic [NUM_CH-1:0] bits);
    int c;
    c = cyc;
    hist[c & HMASK] = bits;
    for (int k = 0; k < NUM_CH; k++) bin[k] = (c >= k) ? hist[(c - k) & HMASK][k] : 1'b0;
    start   = s;
    bin_val = v;
    if (s) begin
      if (!in_frame(c)) run_from = c + 1;
      run_until = 32'h7fffffff;
      for (int k = 0; k < NUM_CH; k++)
        while (exp_q[k].size() > 0 && exp_q[k][$].cyc > c) void'(exp_q[k].pop_back());
      while (done_q.size() > 0 && done_q[$] > c) void'(done_q.pop_back());
      mbits = 0; mwords = 0; mfull = 1'b0; m_ovf = 1'b0;
      for (int k = 0; k < NUM_CH; k++) mword[k] = '0;
    end else if (v && in_frame(c)) begin
      if (mfull) m_ovf = 1'b1;
      else begin
        for (int k = 0; k < NUM_CH; k++) mword[k] = {mword[k][WORD_W-2:0], bits[k]};
        mbits++;
        if (mbits == WORD_W) begin
          for (int k = 0; k < NUM_CH; k++) exp_q[k].push_back('{c + 1 + k, AW'(mwords), mword[k]});
          mbits = 0;
          mwords++;
          if (mwords == DEPTH) begin
            mfull     = 1'b1;
            run_until = c + 1 + NUM_CH;
            done_q.push_back(c + 1 + NUM_CH);
          end
        end
      end
    end
    tick();
  endtask

  wr_t e;
  w2_t e2;

  // Main-instance monitor: writes, busy and done against the scoreboard.
  always @(negedge clk) if (mon_on) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (wea[k]) begin
        if (exp_q[k].size() == 0) check($sformatf("wea%0d_spurious", k), 1, 0);
        else begin
          e = exp_q[k].pop_front();
          check($sformatf("wr%0d_cyc", k), cyc, e.cyc);
          check($sformatf("wr%0d_addr", k), addr[k*AW +: AW], e.a);
          check($sformatf("wr%0d_data", k), dout[k*WORD_W +: WORD_W], e.d);
        end
      end else if (exp_q[k].size() > 0 && exp_q[k][0].cyc < cyc) begin
        check($sformatf("wea%0d_missing", k), 0, 1);
        void'(exp_q[k].pop_front());
      end
    end
    check("busy", busy, in_frame(cyc));
    if (done) begin
      if (done_q.size() == 0) check("done_spurious", 1, 0);
      else check("done_cyc", cyc, done_q.pop_front());
    end else if (done_q.size() > 0 && done_q[0] < cyc) begin
      check("done_missing", 0, 1);
      void'(done_q.pop_front());
    end
  end

  // Aligned-instance monitor.
  always @(negedge clk) if (mon_on) begin
    if (wea2 != '0) begin
      if (q2.size() == 0) check("d2_wea_spurious", wea2, 0);
      else begin
        e2 = q2.pop_front();
        check("d2_wr_cyc", cyc, e2.cyc);
        check("d2_wea", wea2, 4'hF);
        check("d2_addr", addr2, {4{e2.a}});
        check("d2_data", dout2, e2.d);
      end
    end else if (q2.size() > 0 && q2[0].cyc < cyc) begin
      check("d2_wea_missing", 0, 1);
      void'(q2.pop_front());
    end
    if (done2) begin
      if (done2_q.size() == 0) check("d2_done_spurious", 1, 0);
      else check("d2_done_cyc", cyc, done2_q.pop_front());
    end else if (done2_q.size() > 0 && done2_q[0] < cyc) begin
      check("d2_done_missing", 0, 1);
      void'(done2_q.pop_front());
    end
  end

  task automatic full_frame_beats();
    for (int i = 0; i < WORD_W * DEPTH; i++) drive(1'b0, 1'b1, (i % 2) ? 16'hFFFF : 16'h0000);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000);
  endtask

  int pend;
  logic [31:0] mw2;
  int nb2, na2;

  initial begin
    for (int i = 0; i <= HMASK; i++) hist[i] = '0;
    for (int k = 0; k < NUM_CH; k++) mword[k] = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", (dout == '0), 1);
    check("rst_addr", (addr == '0), 1);
    check("rst_wea", wea, 0);
    check("rst_flags", {busy, done, overflow}, 0);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    tick();

    // 1: idle with toggling valid, no start
    for (int i = 0; i < 50; i++) drive(1'b0, i[0], 16'($urandom));
    check("t1_dout", (dout == '0), 1);
    check("t1_addr", (addr == '0), 1);
    check("t1_ovf", overflow, 0);

    // 2: contiguous frame, alternating 0/1 bits -> 0x55555555 words
    drive(1'b1, 1'b0, 16'h0000);
    full_frame_beats();
    idle(30);
    check("t2_ovf", overflow, 0);

    // 3: 50% duty valid; start lands exactly on the DONE cycle
    drive(1'b1, 1'b0, 16'h0000);
    for (int i = 0, j = 0; i < 2 * WORD_W * DEPTH; i++) begin
      if (i % 2 == 0) begin
        drive(1'b0, 1'b1, (j % 2) ? 16'hFFFF : 16'h0000);
        j++;
      end else drive(1'b0, 1'b0, 16'hFFFF);
    end
    for (int i = 0; i < 200 && done_q.size() > 0 && cyc < done_q[0]; i++) drive(1'b0, 1'b0, 16'h0000);
    check("t3_at_done", done, 1);

    // 4: start on DONE, full frame then 5 extra beats -> sticky overflow
    drive(1'b1, 1'b0, 16'h0000);
    full_frame_beats();
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 16'($urandom));
    check("t4_ovf_set", overflow, 1);
    idle(30);
    check("t4_ovf_held", overflow, m_ovf);

    // 5: start clears overflow; abort at beat 200 with a coincident beat
    drive(1'b1, 1'b0, 16'h0000);
    check("t5_ovf_clr", overflow, 0);
    for (int i = 0; i < 200; i++) drive(1'b0, 1'b1, 16'($urandom));
    drive(1'b1, 1'b1, 16'hFFFF);
    check("t5_abort_addr", (addr == '0), 1);
    check("t5_abort_dout", (dout == '0), 1);
    for (int i = 0; i < WORD_W * DEPTH; i++) drive(1'b0, 1'b1, 16'($urandom));
    idle(30);
    check("t5_ovf", overflow, 0);

    // 6: aligned 4-channel instance, 24 beats
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    mw2 = '0; nb2 = 0; na2 = 0;
    for (int i = 0; i < 24; i++) begin
      bin_val2 = 1'b1;
      bin2     = 4'($urandom);
      for (int k = 0; k < 4; k++) mw2[k*8 +: 8] = {mw2[k*8 +: 7], bin2[k]};
      nb2++;
      if (nb2 == 8) begin
        q2.push_back('{cyc + 1, 2'(na2), mw2});
        if (na2 == 2) done2_q.push_back(cyc + 2);
        nb2 = 0;
        na2++;
      end
      tick();
      if (i == 10) check("d2_busy_run", busy2, 1);
    end
    bin_val2 = 1'b0;
    repeat (10) tick();
    check("d2_busy_end", busy2, 0);
    check("d2_ovf", overflow2, 0);

    pend = 0;
    for (int k = 0; k < NUM_CH; k++) pend += exp_q[k].size();
    check("pending_writes", pend, 0);
    check("pending_done", done_q.size(), 0);
    check("d2_pending", q2.size() + done2_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
